// File: rtl/rf_arb_pkg.sv
// Shared widths, defaults and queue entry type for the register-file write arbiter.
package rf_arb_pkg;

  localparam int unsigned REG_W          = 5;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned NREG           = 32;
  localparam int unsigned DEPTH_DEF      = 2;
  localparam int unsigned STARVE_MAX_DEF = 3;
  localparam int unsigned CONF_W         = 16;

  typedef struct packed {
    logic [REG_W-1:0]  wn;
    logic [DATA_W-1:0] d;
  } wq_entry_t;

endpackage

// File: rtl/rf_wq_fifo.sv
// DEPTH-entry queue of long-latency results; DEPTH must be a power of two.
module rf_wq_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic      clk,
  input  logic      clrn,
  input  logic      push,
  input  logic      pop,
  input  wq_entry_t din,
  output wq_entry_t head_c,
  output logic      full_c,
  output logic      empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  wq_entry_t      mem [DEPTH];
  logic           do_push_c;
  logic           do_pop_c;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push_c = push & ~full_c;
  assign do_pop_c  = pop & ~empty_c;
  assign head_c    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and a long-latency queue.
// Optional conflict statistics output enabled by RF_ARB_STATS_EN.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_wn,
  input  logic [DATA_W-1:0] wb_d,
  input  logic              lu_valid,
  input  logic [REG_W-1:0]  lu_wn,
  input  logic [DATA_W-1:0] lu_d,
  output logic              lu_ready,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_wn,
  input  logic [REG_W-1:0]  chk_rna,
  input  logic [REG_W-1:0]  chk_rnb,
  input  logic [REG_W-1:0]  chk_wn,
  output logic              stall,
  output logic              wb_hold,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_wn,
  output logic [DATA_W-1:0] rf_d,
`ifdef RF_ARB_STATS_EN
  output logic [CONF_W-1:0] conflicts,
`endif
  output logic              err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic                wb_req_c;
  logic                push_c;
  logic                grant_q_c;
  logic                grant_wb_c;
  logic                q_full_c;
  logic                q_empty_c;
  wq_entry_t           q_head_c;
  wq_entry_t           lu_ent_c;
  logic [STARVE_W-1:0] starve_cnt;
  logic [NREG-1:0]     pending;
  logic [NREG-1:0]     set_c;
  logic [NREG-1:0]     clr_c;

  // Writes to r0 are treated as absent on both sources.
  assign wb_req_c   = wb_we & (wb_wn != '0);
  assign push_c     = lu_valid & ~q_full_c & (lu_wn != '0);
  assign lu_ready   = ~q_full_c;
  assign lu_ent_c   = '{wn: lu_wn, d: lu_d};
  assign grant_q_c  = ~q_empty_c & (wb_hold | ~wb_req_c);
  assign grant_wb_c = wb_req_c & ~grant_q_c;

  rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push    (push_c),
    .pop     (grant_q_c),
    .din     (lu_ent_c),
    .head_c  (q_head_c),
    .full_c  (q_full_c),
    .empty_c (q_empty_c)
  );

  // Register-file write port; wn/d hold their last value while idle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rf_we <= 1'b0;
      rf_wn <= '0;
      rf_d  <= '0;
    end else begin
      rf_we <= grant_q_c | grant_wb_c;
      if (grant_q_c) begin
        rf_wn <= q_head_c.wn;
        rf_d  <= q_head_c.d;
      end else if (grant_wb_c) begin
        rf_wn <= wb_wn;
        rf_d  <= wb_d;
      end
    end
  end

  // A non-empty queue that is not granted has lost to writeback this cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      starve_cnt <= '0;
      wb_hold    <= 1'b0;
    end else if (q_empty_c || grant_q_c) begin
      starve_cnt <= '0;
      wb_hold    <= 1'b0;
    end else if (starve_cnt == STARVE_W'(STARVE_MAX)) begin
      wb_hold    <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Scoreboard set/clear masks; a same-cycle set overrides the clear.
  always_comb begin
    set_c = '0;
    clr_c = '0;
    if (iss_valid) set_c[iss_wn] = 1'b1;
    if (grant_q_c) clr_c[q_head_c.wn] = 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_c) | set_c) & {{(NREG-1){1'b1}}, 1'b0};
    end
  end

  assign stall = pending[chk_rna] | pending[chk_rnb] | pending[chk_wn];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      err <= 1'b0;
    end else if (wb_we && wb_hold) begin
      err <= 1'b1;
    end
  end

`ifdef RF_ARB_STATS_EN
  // Saturating count of cycles where both sources contend.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      conflicts <= '0;
    end else if (wb_req_c && !q_empty_c && (conflicts != '1)) begin
      conflicts <= conflicts + CONF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue/arith reference model plus directed literal checks.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int SMAX = 3;

  logic              clk = 1'b0;
  logic              clrn = 1'b0;
  logic              wb_we = 1'b0;
  logic [REG_W-1:0]  wb_wn = '0;
  logic [DATA_W-1:0] wb_d = '0;
  logic              lu_valid = 1'b0;
  logic [REG_W-1:0]  lu_wn = '0;
  logic [DATA_W-1:0] lu_d = '0;
  logic              lu_ready;
  logic              iss_valid = 1'b0;
  logic [REG_W-1:0]  iss_wn = '0;
  logic [REG_W-1:0]  chk_rna = '0;
  logic [REG_W-1:0]  chk_rnb = '0;
  logic [REG_W-1:0]  chk_wn = '0;
  logic              stall;
  logic              wb_hold;
  logic              rf_we;
  logic [REG_W-1:0]  rf_wn;
  logic [DATA_W-1:0] rf_d;
  logic              err;
`ifdef RF_ARB_STATS_EN
  logic [CONF_W-1:0] conflicts;
`endif

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .wb_we     (wb_we),
    .wb_wn     (wb_wn),
    .wb_d      (wb_d),
    .lu_valid  (lu_valid),
    .lu_wn     (lu_wn),
    .lu_d      (lu_d),
    .lu_ready  (lu_ready),
    .iss_valid (iss_valid),
    .iss_wn    (iss_wn),
    .chk_rna   (chk_rna),
    .chk_rnb   (chk_rnb),
    .chk_wn    (chk_wn),
    .stall     (stall),
    .wb_hold   (wb_hold),
    .rf_we     (rf_we),
    .rf_wn     (rf_wn),
    .rf_d      (rf_d),
`ifdef RF_ARB_STATS_EN
    .conflicts (conflicts),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, a pending-bit set and a loss counter.
  wq_entry_t       mq[$];
  bit [NREG-1:0]   mpend;
  int              mloss;
  bit              mhold;
  bit              merr;
  bit              mwe;
  logic [REG_W-1:0]  mwn;
  logic [DATA_W-1:0] md;
  int              mconf;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mq.delete();
      mpend = '0;
      mloss = 0;
      mhold = 1'b0;
      merr  = 1'b0;
      mwe   = 1'b0;
      mwn   = '0;
      md    = '0;
      mconf = 0;
    end else begin
      bit        req;
      bit        qn;
      bit        room;
      bit        gq;
      wq_entry_t e;
      req  = wb_we && (wb_wn != 0);
      qn   = (mq.size() != 0);
      room = (mq.size() < DEPTH);
      if (mhold && wb_we) merr = 1'b1;
      if (req && qn && mconf < 65535) mconf++;
      gq  = qn && (mhold || !req);
      mwe = gq || req;
      if (gq) begin
        e = mq.pop_front();
        mwn = e.wn;
        md  = e.d;
        mpend[e.wn] = 1'b0;
      end else if (req) begin
        mwn = wb_wn;
        md  = wb_d;
      end
      if (!qn || gq) begin
        mhold = 1'b0;
        mloss = 0;
      end else begin
        if (mloss >= SMAX) mhold = 1'b1;
        mloss++;
      end
      if (lu_valid && room && lu_wn != 0) mq.push_back(wq_entry_t'{wn: lu_wn, d: lu_d});
      if (iss_valid && iss_wn != 0) mpend[iss_wn] = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("rf_we", rf_we, mwe);
    if (mwe) begin
      check("rf_wn", rf_wn, mwn);
      check("rf_d", rf_d, md);
    end
    check("wb_hold", wb_hold, mhold);
    check("err", err, merr);
    check("lu_ready", lu_ready, mq.size() < DEPTH);
    check("stall", stall, mpend[chk_rna] | mpend[chk_rnb] | mpend[chk_wn]);
`ifdef RF_ARB_STATS_EN
    check("conflicts", conflicts, mconf);
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_wn", rf_wn, 0);
    check("rst_rf_d", rf_d, 0);
    check("rst_lu_ready", lu_ready, 1);
    check("rst_stall", stall, 0);
    check("rst_wb_hold", wb_hold, 0);
    check("rst_err", err, 0);
    clrn = 1'b1;

    // Issue r5, push its result, written one cycle after the push
    iss_valid = 1'b1; iss_wn = 5; chk_rna = 5;
    step();
    check("t1_stall_set", stall, 1);
    iss_valid = 1'b0;
    lu_valid = 1'b1; lu_wn = 5; lu_d = 32'hAA;
    step();
    check("t1_push_no_write", rf_we, 0);
    check("t1_stall_hold", stall, 1);
    lu_valid = 1'b0;
    step();
    check("t1_we", rf_we, 1);
    check("t1_wn", rf_wn, 5);
    check("t1_d", rf_d, 32'hAA);
    check("t1_stall_clr", stall, 0);
    chk_rna = 0;

    // Writeback r3 beats queued r7, r7 follows
    lu_valid = 1'b1; lu_wn = 7; lu_d = 32'h77;
    step();
    lu_valid = 1'b0;
    wb_we = 1'b1; wb_wn = 3; wb_d = 32'h33;
    step();
    check("t2_wb_wn", rf_wn, 3);
    check("t2_wb_d", rf_d, 32'h33);
    wb_we = 1'b0;
    step();
    check("t2_q_wn", rf_wn, 7);
    check("t2_q_d", rf_d, 32'h77);

    // Starvation: writeback wins STARVE_MAX+1 times, then hold forces the queue
    wb_we = 1'b1; wb_wn = 4; wb_d = 32'h40;
    lu_valid = 1'b1; lu_wn = 10; lu_d = 32'h1010;
    step();
    lu_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wb_d = 32'h40 + i;
      step();
      check("t3_hold_low", wb_hold, 0);
      check("t3_wb_wn", rf_wn, 4);
    end
    wb_d = 32'h44;
    step();
    check("t3_hold_high", wb_hold, 1);
    check("t3_wb_d4", rf_d, 32'h44);
    // Pipeline violates hold once on purpose
    wb_d = 32'h45;
    step();
    check("t3_q_wn", rf_wn, 10);
    check("t3_q_d", rf_d, 32'h1010);
    check("t3_hold_drop", wb_hold, 0);
    check("t3_err", err, 1);
    wb_we = 1'b0;

    // Fill the queue while writeback is busy; no pass-through on full
    wb_we = 1'b1; wb_wn = 6; wb_d = 32'h60;
    lu_valid = 1'b1; lu_wn = 11; lu_d = 32'hB0;
    step();
    lu_wn = 12; lu_d = 32'hC0;
    step();
    check("t4_full", lu_ready, 0);
    lu_wn = 13; lu_d = 32'hD0; wb_we = 1'b0;
    step();
    check("t4_pop11", rf_wn, 11);
    check("t4_ready", lu_ready, 1);
    lu_valid = 1'b0;
    step();
    check("t4_pop12", rf_wn, 12);
    step();
    check("t4_13_dropped", rf_we, 0);
    for (int i = 0; i < 5; i++) begin
      lu_valid = 1'b1; lu_wn = REG_W'(14 + i); lu_d = 32'h100 + i;
      step();
      if (i > 0) begin
        check("t4_wrap_wn", rf_wn, 14 + i - 1);
        check("t4_wrap_d", rf_d, 32'h100 + i - 1);
      end
    end
    lu_valid = 1'b0;
    step();
    check("t4_wrap_last", rf_wn, 18);

    // Scoreboard: r9 stalls until granted; r0 never stalls or writes
    iss_valid = 1'b1; iss_wn = 9; chk_rna = 9; chk_rnb = 0; chk_wn = 9;
    step();
    iss_valid = 1'b0;
    check("t5_stall", stall, 1);
    lu_valid = 1'b1; lu_wn = 0; lu_d = 32'hDEAD;
    step();
    check("t5_r0_ready", lu_ready, 1);
    lu_valid = 1'b0;
    step();
    check("t5_r0_nowrite", rf_we, 0);
    chk_rna = 0; chk_wn = 0;
    #1;
    check("t5_rnb0_nostall", stall, 0);
    chk_rna = 9;
    lu_valid = 1'b1; lu_wn = 9; lu_d = 32'h99;
    step();
    check("t5_stall_push", stall, 1);
    lu_valid = 1'b0;
    step();
    check("t5_r9_wn", rf_wn, 9);
    check("t5_stall_clr", stall, 0);
    chk_rna = 0;
    iss_valid = 1'b1; iss_wn = 0;
    step();
    iss_valid = 1'b0;
    check("t5_iss0", stall, 0);

    // Reset with two queued entries and a pending register
    iss_valid = 1'b1; iss_wn = 20;
    wb_we = 1'b1; wb_wn = 2; wb_d = 32'h22;
    lu_valid = 1'b1; lu_wn = 21; lu_d = 32'h21;
    step();
    iss_valid = 1'b0; lu_wn = 22; lu_d = 32'h22;
    step();
    check("t6_full", lu_ready, 0);
    lu_valid = 1'b0; wb_we = 1'b0; chk_rna = 20;
    clrn = 1'b0;
    #1;
    check("t6_rf_we", rf_we, 0);
    check("t6_ready", lu_ready, 1);
    check("t6_stall", stall, 0);
    check("t6_err", err, 0);
    check("t6_hold", wb_hold, 0);
    step();
    clrn = 1'b1;
    step();
    check("t6_no_write1", rf_we, 0);
    step();
    check("t6_no_write2", rf_we, 0);
    check("t6_ready2", lu_ready, 1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single write port of the 32×32 register file (r0 hard-wired zero, written on negedge clk) between the in-order pipeline writeback stage and a long-latency unit (divider / load return). It buffers long-latency results in a small queue, tracks outstanding long-latency destinations in a scoreboard, and raises stall or hold signals so that no write is lost and no hazard escapes.

## Interface
Parameters:
- DEPTH, 2: long-latency queue entries (power of two, ≥2).
- STARVE_MAX, 3: consecutive cycles a non-empty queue may lose to writeback before `wb_hold` is raised.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clrn  in  1  reset, asynchronous, active-low.
- wb_we  in  1  pipeline writeback request; always accepted unless `wb_hold`.
- wb_wn  in  5  pipeline destination.
- wb_d  in  32  pipeline data.
- lu_valid  in  1  long-latency result valid.
- lu_wn  in  5  long-latency destination.
- lu_d  in  32  long-latency data.
- lu_ready  out  1  queue can accept; equals !full.
- iss_valid  in  1  decode issues a long-latency op this cycle.
- iss_wn  in  5  destination of the issued op.
- chk_rna, chk_rnb, chk_wn  in  5 each  decode source and destination numbers to check.
- stall  out  1  combinational; chk register pending in scoreboard.
- wb_hold  out  1  registered; pipeline must not assert `wb_we` next cycle.
- rf_we, rf_wn, rf_d  out  1/5/32  registered; drive the register file's `we`, `wn`, `d`.
- err  out  1  sticky; `wb_we` seen while `wb_hold` high.

## Operation
- Queue push: `lu_valid & lu_ready`. If `lu_wn==0`, the handshake completes but nothing is enqueued and the scoreboard is untouched.
- Grant, evaluated each posedge:
  - If `wb_hold==1` and the queue is non-empty, the queue head wins.
  - Otherwise, if `wb_we` with `wb_wn!=0`, writeback wins.
  - Otherwise, if the queue is non-empty, the queue head wins.
  - Otherwise, `rf_we` is 0 next cycle.
- `wb_we` with `wb_wn==0` counts as no request.
- Starvation counter:
  - Increments each cycle the queue is non-empty and writeback wins.
  - Clears when the queue wins or the queue is empty.
  - `wb_hold` is set the cycle after the counter reaches STARVE_MAX and clears after one queue grant.
- Scoreboard: 31 pending bits (r1..r31).
  - Set on `iss_valid & iss_wn!=0`.
  - Cleared when the queue head with that wn is granted.
  - Set and clear of the same register in the same cycle: set wins.
- `stall = pending[chk_rna] | pending[chk_rnb] | pending[chk_wn]`; index 0 always reads not-pending. Covering `chk_wn` means only one op per register is outstanding (no WAW).
- Simultaneous push on a full queue and pop: `lu_ready` is still 0 (no pass-through).

## Timing
- Request sampled at posedge N produces `rf_we/wn/d` valid after posedge N. The register file writes at the negedge within cycle N.
- Queue push-to-write minimum latency: push at posedge N, granted at posedge N+1 (entry visible one cycle after push).
- `wb_hold` asserts one cycle after the counter hits the limit.
- `stall` and `lu_ready` are combinational from current state.
- Reset state, reset mid-operation included:
  - Queue emptied (contents discarded); pending bits and counters cleared.
  - `rf_we=0`, `rf_wn=0`, `rf_d=0`, `wb_hold=0`, `err=0`.
  - `lu_ready=1`, `stall=0`.

## Configuration
- RF_ARB_STATS_EN defined: adds output `conflicts[15:0]`, a saturating count of cycles where both a valid writeback request and a non-empty queue were present, cleared by clrn.
- RF_ARB_STATS_EN undefined: port and counter absent; all other behaviour identical.

## Structure
- Package `rf_arb_pkg`: REG_W=5, DATA_W=32, NREG=32, default DEPTH and STARVE_MAX, and a queue entry struct {wn, d}.
- Sub-module `rf_wq_fifo` holds the DEPTH-entry queue: pointers with wrap, full/empty, registered storage.
- Grant, starvation counter and scoreboard live in the top.

## Test plan
- After reset, `lu_valid=1`, `lu_wn=5`, `lu_d=0xAA`, no writeback → `rf_we=1`, `rf_wn=5`, `rf_d=0xAA` one cycle after the push; `pending[5]` clears.
- Writeback to r3 on the same cycle the queue holds r7 → r3 written first, r7 the next cycle.
- Writeback every cycle with a queue entry pending → after STARVE_MAX writeback wins, `wb_hold=1` next cycle; the queue entry is written and `wb_hold` drops.
- Fill the queue (DEPTH=2) while writeback is busy → `lu_ready=0`; pointer wrap verified across 5 push/pop pairs.
- `iss_valid`, `iss_wn=9`, then `chk_rna=9` → `stall=1` until r9 is granted; `chk_rnb=0` never stalls; `lu_wn=0` is accepted and never written.
- `clrn` low with 2 queued entries → nothing written after reset, `lu_ready=1`, all pending bits 0, `err=0`.
